// File: rtl/fp_d_pkg.sv
// Shared IEEE-754 double-precision field constants for the integer-to-double
// conversion path.
package fp_d_pkg;

  localparam int EXP_BIAS = 1023;
  localparam int NEXP     = 11;
  localparam int NSIG     = 52;

  localparam logic [63:0] D_POS_ZERO = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/fp_cvt_d_w_core.sv
// Combinational 32-bit integer to double conversion (fcvt.d.w / fcvt.d.wu).
// Every 32-bit integer fits in the 53-bit significand, so the result is exact.
module fp_cvt_d_w_core
  import fp_d_pkg::*;
(
  input  logic [31:0] src,
  input  logic        is_signed,
  output logic [63:0] d
);

  logic            neg;
  logic [31:0]     mag;
  logic [4:0]      msb;
  logic [31:0]     norm;
  logic [NEXP-1:0] exp_f;
  logic [NSIG-1:0] frac;

  always_comb begin
    neg = is_signed & src[31];
    // Two's complement negation maps 0x80000000 onto itself, i.e. 2^31 unsigned.
    mag = neg ? (~src + 32'd1) : src;
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm  = mag << (5'd31 - msb);
    exp_f = NEXP'(EXP_BIAS) + NEXP'(msb);
    // Implicit leading one at norm[31] is dropped; the rest is left-aligned.
    frac  = {norm[30:0], {(NSIG - 31){1'b0}}};
    d     = (mag == 32'd0) ? D_POS_ZERO : {neg, exp_f, frac};
  end

endmodule

// File: rtl/fp_cvt_d_w_sched.sv
// Round-robin scheduler sharing one integer-to-double converter among NREQ
// requesters through a two-stage pipeline with a backpressured result port.
module fp_cvt_d_w_sched
  import fp_d_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 5,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_src,
  input  logic [NREQ-1:0]      req_signed,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [TAGW-1:0]      out_tag,
  output logic [IDW-1:0]       out_id,
  output logic                 busy
);

  // Handshake: a beat moves when valid and ready are both high in the same
  // cycle; valid must not wait for ready, and ready is computed without
  // looking at anything but the arbitration choice.

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_src_q, s1_src_d;
  logic            s1_signed_q, s1_signed_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;

  logic            out_valid_q, out_valid_d;
  logic [63:0]     out_data_q, out_data_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic [IDW-1:0]  out_id_q, out_id_d;

  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            adv;
  logic            s1_acc;
  logic            grant_en;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic            xfer;
  logic [31:0]     sel_src;
  logic            sel_signed;
  logic [TAGW-1:0] sel_tag;
  logic [63:0]     core_d;

  fp_cvt_d_w_core u_core (
    .src       (s1_src_q),
    .is_signed (s1_signed_q),
    .d         (core_d)
  );

  assign adv      = !out_valid_q | out_ready;
  assign s1_acc   = !s1_valid_q | adv;
  assign grant_en = s1_acc & !flush & !rst;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    xfer       = grant_en & gnt_found;
    sel_src    = '0;
    sel_signed = 1'b0;
    sel_tag    = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_src    = req_src[32*i +: 32];
        sel_signed = req_signed[i];
        sel_tag    = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_src_d    = s1_src_q;
    s1_signed_d = s1_signed_q;
    s1_tag_d    = s1_tag_q;
    s1_id_d     = s1_id_q;
    if (s1_acc) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_src_d    = sel_src;
        s1_signed_d = sel_signed;
        s1_tag_d    = sel_tag;
        s1_id_d     = gnt_idx;
      end
    end
    if (flush) s1_valid_d = 1'b0;
  end

  // Output registers only load on advance, so they hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_id_d    = out_id_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = core_d;
        out_tag_d  = s1_tag_q;
        out_id_d   = s1_id_q;
      end
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_src_q    <= '0;
      s1_signed_q <= 1'b0;
      s1_tag_q    <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= D_POS_ZERO;
      out_tag_q   <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_src_q    <= s1_src_d;
      s1_signed_q <= s1_signed_d;
      s1_tag_q    <= s1_tag_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_id    = out_id_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_fp_cvt_d_w_sched.sv
// Directed bench for the shared integer-to-double scheduler: value corners,
// round-robin order, backpressure, flush and mid-stream reset.
module tb_fp_cvt_d_w_sched;

  localparam int NREQ = 4;
  localparam int TAGW = 5;
  localparam int IDW  = 2;
  localparam int EW   = IDW + TAGW + 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_src = '0;
  logic [NREQ-1:0]      req_signed = '0;
  logic [NREQ*TAGW-1:0] req_tag = '0;
  logic                 flush = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [63:0]          out_data;
  logic [TAGW-1:0]      out_tag;
  logic [IDW-1:0]       out_id;
  logic                 busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  fp_cvt_d_w_sched #(.NREQ(NREQ), .TAGW(TAGW), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_signed (req_signed),
    .req_tag    (req_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_id     (out_id),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_cvt(input logic [31:0] src, input logic sgn);
    longint v;
    v = sgn ? longint'($signed(src)) : longint'({32'h0, src});
    return $realtobits(real'(v));
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", {out_id, out_tag, out_data}, '0);
        else check("result", {out_id, out_tag, out_data}, exp_q.pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i])
          exp_q.push_back({IDW'(i), req_tag[i*TAGW +: TAGW],
                           exp_cvt(req_src[i*32 +: 32], req_signed[i])});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] src, input logic sgn,
                         input logic [TAGW-1:0] tag);
    req_src[i*32 +: 32]     = src;
    req_signed[i]           = sgn;
    req_tag[i*TAGW +: TAGW] = tag;
  endtask

  // One isolated request; checks the grant, the two-cycle latency and the value.
  task automatic send_one(input int i, input logic [31:0] src, input logic sgn,
                          input logic [TAGW-1:0] tag, input logic [63:0] exp_d);
    set_req(i, src, sgn, tag);
    req_valid = NREQ'(1) << i;
    #1;
    check("single_grant", req_ready, NREQ'(1) << i);
    tick();
    req_valid = '0;
    check("latency_n1", out_valid, 1'b0);
    tick();
    check("latency_n2", out_valid, 1'b1);
    check("value", out_data, exp_d);
    check("id_tag", {out_id, out_tag}, {IDW'(i), tag});
    tick();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    check("drain", {exp_q.size() == 0, busy}, {1'b1, 1'b0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_valid = '1;
    repeat (3) tick();
    check("rst_ready", req_ready, '0);
    check("rst_out", {out_valid, busy, out_id, out_tag, out_data}, '0);
    rst = 1'b0;
    req_valid = '0;
    tick();

    // Value corners, issued one at a time; the last from req3 leaves the pointer at 0.
    send_one(0, 32'h0000_0001, 1'b0, 5'd5,  64'h3FF0_0000_0000_0000);
    send_one(1, 32'hFFFF_FFFF, 1'b0, 5'd9,  64'h41EF_FFFF_FFE0_0000);
    send_one(2, 32'hFFFF_FFFF, 1'b1, 5'd17, 64'hBFF0_0000_0000_0000);
    send_one(0, 32'h8000_0000, 1'b0, 5'd30, 64'h41E0_0000_0000_0000);
    send_one(1, 32'h0000_0000, 1'b1, 5'd2,  64'h0000_0000_0000_0000);
    send_one(3, 32'h8000_0000, 1'b1, 5'd31, 64'hC1E0_0000_0000_0000);

    // Fairness: all requesters held valid, full-rate streaming.
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, 1'($urandom_range(0, 1)), TAGW'(i + 20));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) req_src[i*32 +: 32] = $urandom;
      #1;
      check("rr_grant", req_ready, NREQ'(1) << (k % NREQ));
      if (k >= 2) check("stream_valid", out_valid, 1'b1);
      tick();
    end
    req_valid = '0;
    wait_drain();

    // Backpressure: two grants fill both stages, then arbitration stalls.
    set_req(0, 32'hFFFF_FFF9, 1'b1, 5'd7);
    set_req(1, 32'd1000, 1'b0, 5'd8);
    set_req(2, 32'd3, 1'b1, 5'd11);
    set_req(3, 32'h7FFF_FFFF, 1'b1, 5'd12);
    out_ready = 1'b0;
    req_valid = '1;
    #1;
    check("bp_grant0", req_ready, 4'b0001);
    tick();
    check("bp_grant1", req_ready, 4'b0010);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("bp_stall_ready", req_ready, '0);
      check("bp_hold", {out_valid, out_id, out_data}, {1'b1, 2'd0, 64'hC01C_0000_0000_0000});
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();
    req_valid = '0;
    wait_drain();

    // Reset while streaming.
    req_valid = '1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_ready", req_ready, '0);
    tick();
    exp_q.delete();
    check("rst_mid_out", {out_valid, busy, out_id, out_tag, out_data}, '0);
    rst = 1'b0;
    req_valid = 4'b1100;
    #1;
    check("rst_first_grant", req_ready, 4'b0100);
    tick();

    // Flush with both stages full; pointer sits at 1 afterwards.
    req_valid = 4'b0011;
    out_ready = 1'b0;
    #1;
    check("pre_flush_grant", req_ready, 4'b0001);
    tick();
    req_valid = '1;
    flush = 1'b1;
    #1;
    check("flush_no_grant", req_ready, '0);
    check("flush_busy", busy, 1'b1);
    tick();
    exp_q.delete();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_flush", {out_valid, busy}, 2'b00);
    check("post_flush_ptr", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_cvt_d_w_sched.md
Name: fp_cvt_d_w_sched

Overview:
- Round-robin scheduler that shares one integer-to-double conversion datapath among NREQ requesters.
- Accepts 32-bit signed (fcvt.d.w) or unsigned (fcvt.d.wu) operands over per-requester valid/ready.
- Sequences each operand through a 2-stage registered pipeline.
- Returns the IEEE-754 double with the requester's tag and id through a single backpressured result port. Sits between the D-extension issue logic and the FP writeback arbiter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 5, width of the destination tag carried with each request.
- IDW, 2, width of the requester index; must equal clog2(NREQ).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- req_src  in  NREQ*32  operand; requester i occupies bits [32*i+31:32*i]
- req_signed  in  NREQ  1 = fcvt.d.w, 0 = fcvt.d.wu
- req_tag  in  NREQ*TAGW  destination tag per requester
- flush  in  1  discard all in-flight conversions
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  64  double result
- out_tag  out  TAGW  tag of the result
- out_id  out  IDW  index of the originating requester
- busy  out  1  high when any pipeline stage is occupied

Behaviour:
- Reset: on rst, all valid bits (s1_valid, out_valid), req_ready, out_data, out_tag, out_id and busy are 0, and the round-robin pointer is 0. rst has priority over flush.
- Pipeline advance: adv = !out_valid | out_ready.
- Stage-1 accept: s1_acc = !s1_valid | adv.
- Arbitration (combinational):
  - If s1_acc and !flush, assert req_ready for exactly one requester: the first valid one at or after the pointer, wrapping modulo NREQ.
  - Otherwise all req_ready are 0.
  - req_ready never depends on req_valid of the same requester beyond this selection. The grant may drop if that requester's valid drops.
- On a transfer from requester g:
  - Capture src, signed, tag and g into stage 1; s1_valid is set.
  - The pointer becomes (g+1) mod NREQ.
  - With no transfer, the pointer holds.
- Stage 1 to stage 2: when adv is high, out_valid <= s1_valid and the converted result registers into out_data/out_tag/out_id. When adv is low, stage 2 and stage 1 both hold.
- Latency and throughput: a grant in cycle N gives out_valid in cycle N+2 with no backpressure. Throughput is 1 result per cycle.
- Output hold: out_data, out_tag and out_id are stable while out_valid & !out_ready.
- Conversion is exact; 32-bit integers fit in a 53-bit significand, so no rounding logic is needed.
  - Signed input: sign = src[31], magnitude = |src|. 0x80000000 gives magnitude 2^31.
  - Unsigned input: sign = 0.
  - Zero gives +0.0 (all bits 0).
  - Non-zero: exponent = 1023 + msb_index(magnitude); fraction = magnitude shifted so the leading 1 is dropped, left-aligned into 52 bits.
- Flush:
  - The next cycle, s1_valid = 0 and out_valid = 0.
  - No grant is issued in the flush cycle.
  - A result presented with out_ready high in the flush cycle is consumed normally.
- busy = s1_valid | out_valid.
- Simultaneous events: stage-2 drain, stage-1 advance and a new grant may all occur in the same cycle (full-rate streaming).

Decomposition:
- Shared package fp_d_pkg:
  - double field constants: EXP_BIAS = 1023, NEXP = 11, NSIG = 52
  - canonical constant D_POS_ZERO
- Sub-module fp_cvt_d_w_core: combinational datapath.
  - Inputs: src[31:0], is_signed.
  - Output: d[63:0].
  - Uses priority leading-zero count and shift.
- The scheduler owns arbitration, the pipeline registers and flush only.

Test Plan:
- Single request: req0 sends src=1, unsigned -> out_data=0x3FF0000000000000 two cycles after the grant, out_id=0, tag echoed.
- Value corners:
  - src=0xFFFFFFFF unsigned -> 0x41EFFFFFFFE00000
  - src=0xFFFFFFFF signed -> 0xBFF0000000000000
  - src=0x80000000 signed -> 0xC1E0000000000000
  - src=0x80000000 unsigned -> 0x41E0000000000000
  - src=0 -> 0x0000000000000000
- Fairness: all 4 requesters held valid with out_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles and one result every cycle, in grant order.
- Backpressure: out_ready=0 for 5 cycles with 4 requests pending -> stage 2 and stage 1 fill and then all req_ready are 0. out_data is stable. After release, results drain in order with no loss or duplication.
- Flush: flush asserted with both stages full -> out_valid=0 and busy=0 next cycle, no grant in the flush cycle, and the pointer is unchanged.
- Reset mid-stream: rst asserted while streaming -> all outputs 0 next cycle. The pointer restarts at 0, so the first grant after rst goes to the lowest-index valid requester.
